// File: rtl/multi_alarm_timekeeper.sv
// Timekeeping core: CP50 prescaler to a 1 s tick, 24h hh:mm:ss counters, BCD display, multi-channel alarms.
// Defining HOURLY_CHIME_EN adds the hourly chime sequencer; otherwise chime is tied low.
module multi_alarm_timekeeper #(
  parameter int unsigned CLK_DIV    = 50000000,
  parameter int unsigned NUM_ALARMS = 4,
  parameter int unsigned RING_SECS  = 60
) (
  input  logic                  CP50,
  input  logic                  nCR,
  input  logic                  EN,
  input  logic                  Ctrl24To12,
  input  logic                  AdjH,
  input  logic                  AdjM,
  input  logic                  alm_wr,
  input  logic [3:0]            alm_sel,
  input  logic [4:0]            alm_hour,
  input  logic [5:0]            alm_min,
  input  logic                  alm_arm,
  input  logic                  alm_stop,
  output logic [7:0]            hour_bcd,
  output logic [7:0]            min_bcd,
  output logic [7:0]            sec_bcd,
  output logic                  pm,
  output logic                  tick,
  output logic                  alarm_ring,
  output logic [NUM_ALARMS-1:0] alarm_src,
  output logic                  chime
);

  localparam int unsigned PW = $clog2(CLK_DIV);
  localparam int unsigned RW = 8;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [RW-1:0] RING_LOAD = RW'(RING_SECS);

  typedef enum logic {IDLE, RING} state_e;

  logic [PW-1:0]         presc_q, presc_d;
  logic [5:0]            sec_q, sec_d;
  logic [5:0]            min_q, min_d;
  logic [4:0]            hour_q, hour_d;
  logic                  adjh_q, adjh_d;
  logic                  adjm_q, adjm_d;
  logic                  tick_q, tick_d;
  state_e                state_q, state_d;
  logic [RW-1:0]         ring_cnt_q, ring_cnt_d;
  logic [NUM_ALARMS-1:0] src_q, src_d;
  logic [4:0]            alm_hour_q [NUM_ALARMS];
  logic [4:0]            alm_hour_d [NUM_ALARMS];
  logic [5:0]            alm_min_q [NUM_ALARMS];
  logic [5:0]            alm_min_d [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] alm_arm_q, alm_arm_d;

  logic                  wrap;
  logic                  adj_h;
  logic                  adj_m;
  logic                  carry_m;
  logic                  carry_h;
  logic                  match_evt;
  logic [NUM_ALARMS-1:0] hits;
  logic [4:0]            hour_disp;

  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] t;
    t = 4'(v / 6'd10);
    return {t, 4'(v - 6'(t) * 6'd10)};
  endfunction

  // Prescaler, time counters and adjust; an adjust owns its field and swallows any carry into it
  always_comb begin
    presc_d = presc_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    carry_m = 1'b0;
    carry_h = 1'b0;
    wrap    = EN && (presc_q == PRESC_MAX);
    adj_h   = AdjH && !adjh_q;
    adj_m   = AdjM && !adjm_q;
    adjh_d  = AdjH;
    adjm_d  = AdjM;
    tick_d  = wrap;
    if (EN) presc_d = wrap ? '0 : presc_q + 1'b1;
    if (wrap) begin
      if (sec_q == 6'd59) begin
        sec_d   = 6'd0;
        carry_m = 1'b1;
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end
    if (adj_m || carry_m) min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
    carry_h = carry_m && !adj_m && (min_q == 6'd59);
    if (adj_h || carry_h) hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
  end

  // Alarm table writes
  always_comb begin
    alm_hour_d = alm_hour_q;
    alm_min_d  = alm_min_q;
    alm_arm_d  = alm_arm_q;
    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      if (alm_wr && (alm_sel == 4'(i))) begin
        alm_hour_d[i] = alm_hour;
        alm_min_d[i]  = alm_min;
        alm_arm_d[i]  = alm_arm;
      end
    end
  end

  // Matches are only taken on the tick that lands on second 0
  always_comb begin
    hits      = '0;
    match_evt = wrap && (sec_d == 6'd0);
    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      hits[i] = match_evt && alm_arm_q[i] && (alm_hour_q[i] == hour_d) && (alm_min_q[i] == min_d);
    end
  end

  // Ring FSM; a stop request beats any hit in the same cycle
  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    src_d      = src_q;
    case (state_q)
      IDLE: begin
        if (!alm_stop && (|hits)) begin
          state_d    = RING;
          src_d      = hits;
          ring_cnt_d = RING_LOAD;
        end
      end
      RING: begin
        if (alm_stop) begin
          state_d    = IDLE;
          src_d      = '0;
          ring_cnt_d = '0;
        end else if (|hits) begin
          src_d      = src_q | hits;
          ring_cnt_d = RING_LOAD;
        end else if (wrap) begin
          ring_cnt_d = ring_cnt_q - 1'b1;
          if (ring_cnt_q == RW'(1)) begin
            state_d = IDLE;
            src_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CP50) begin
    if (!nCR) begin
      presc_q    <= '0;
      sec_q      <= '0;
      min_q      <= '0;
      hour_q     <= '0;
      adjh_q     <= 1'b0;
      adjm_q     <= 1'b0;
      tick_q     <= 1'b0;
      state_q    <= IDLE;
      ring_cnt_q <= '0;
      src_q      <= '0;
      alm_hour_q <= '{default: '0};
      alm_min_q  <= '{default: '0};
      alm_arm_q  <= '0;
    end else begin
      presc_q    <= presc_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      adjh_q     <= adjh_d;
      adjm_q     <= adjm_d;
      tick_q     <= tick_d;
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      src_q      <= src_d;
      alm_hour_q <= alm_hour_d;
      alm_min_q  <= alm_min_d;
      alm_arm_q  <= alm_arm_d;
    end
  end

  // 12h display maps 0 to 12 and 13..23 down by 12
  always_comb begin
    hour_disp = hour_q;
    if (Ctrl24To12) begin
      if (hour_q == 5'd0)       hour_disp = 5'd12;
      else if (hour_q > 5'd12)  hour_disp = hour_q - 5'd12;
    end
  end

  assign hour_bcd   = to_bcd(6'(hour_disp));
  assign min_bcd    = to_bcd(min_q);
  assign sec_bcd    = to_bcd(sec_q);
  assign pm         = (hour_q >= 5'd12);
  assign tick       = tick_q;
  assign alarm_ring = (state_q == RING);
  assign alarm_src  = src_q;

`ifdef HOURLY_CHIME_EN
  logic [4:0] chime_ph_q, chime_ph_d;
  logic       chime_q, chime_d;
  logic [3:0] n12;

  // Remaining tick phases; even non-zero phase counts are the high halves of each stroke
  always_comb begin
    chime_ph_d = chime_ph_q;
    if (hour_d == 5'd0)       n12 = 4'd12;
    else if (hour_d > 5'd12)  n12 = 4'(hour_d - 5'd12);
    else                      n12 = 4'(hour_d);
    if (carry_h)                              chime_ph_d = {n12, 1'b0};
    else if (wrap && (chime_ph_q != 5'd0))    chime_ph_d = chime_ph_q - 5'd1;
    chime_d = (chime_ph_d != 5'd0) && !chime_ph_d[0];
  end

  always_ff @(posedge CP50) begin
    if (!nCR) begin
      chime_ph_q <= '0;
      chime_q    <= 1'b0;
    end else begin
      chime_ph_q <= chime_ph_d;
      chime_q    <= chime_d;
    end
  end

  assign chime = chime_q;
`else
  assign chime = 1'b0;
`endif

endmodule

// File: tb/tb_multi_alarm_timekeeper.sv
// Bench for multi_alarm_timekeeper: directed steps plus random traffic against a seconds-of-day model.
module tb_multi_alarm_timekeeper;

  logic       CP50;
  logic       nCR, EN, Ctrl24To12, AdjH, AdjM;
  logic       alm_wr, alm_arm, alm_stop;
  logic [3:0] alm_sel;
  logic [4:0] alm_hour;
  logic [5:0] alm_min;
  logic [7:0] hour_bcd, min_bcd, sec_bcd;
  logic       pm, tick, alarm_ring, chime;
  logic [3:0] alarm_src;

  multi_alarm_timekeeper #(.CLK_DIV(4), .NUM_ALARMS(4), .RING_SECS(3)) dut (
    .CP50(CP50), .nCR(nCR), .EN(EN), .Ctrl24To12(Ctrl24To12), .AdjH(AdjH), .AdjM(AdjM),
    .alm_wr(alm_wr), .alm_sel(alm_sel), .alm_hour(alm_hour), .alm_min(alm_min),
    .alm_arm(alm_arm), .alm_stop(alm_stop), .hour_bcd(hour_bcd), .min_bcd(min_bcd),
    .sec_bcd(sec_bcd), .pm(pm), .tick(tick), .alarm_ring(alarm_ring),
    .alarm_src(alarm_src), .chime(chime)
  );

  initial CP50 = 1'b0;
  always #5 CP50 = ~CP50;

  int n_assert, n_fail;
  int ticks, rises, high;
  logic prev_chime;

  // Reference model: time as seconds of day, alarms as plain arrays
  int       m_presc, m_t, m_left;
  bit       m_ring, m_tick, m_ph, m_pm;
  bit [3:0] m_src;
  bit       m_arm [4];
  int       m_ah [4];
  int       m_am [4];

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] bcd(input int v);
    return 16'((v / 10) * 16 + (v % 10));
  endfunction

  task automatic model_reset();
    m_presc = 0; m_t = 0; m_left = 0; m_ring = 0; m_tick = 0; m_ph = 0; m_pm = 0; m_src = '0;
    for (int i = 0; i < 4; i++) begin m_arm[i] = 0; m_ah[i] = 0; m_am[i] = 0; end
  endtask

  task automatic model_next();
    int h, m, nat, nh, nm, ns;
    bit wrap, ah, am;
    bit [3:0] hits;
    if (!nCR) begin model_reset(); return; end
    wrap = EN && (m_presc == 3);
    if (EN) m_presc = wrap ? 0 : m_presc + 1;
    h = m_t / 3600; m = (m_t / 60) % 60;
    nat = wrap ? (m_t + 1) % 86400 : m_t;
    nh = nat / 3600; nm = (nat / 60) % 60; ns = nat % 60;
    am = AdjM && !m_pm;
    ah = AdjH && !m_ph;
    if (am) begin nm = (m + 1) % 60; nh = h; end
    if (ah) nh = (h + 1) % 24;
    m_t = nh * 3600 + nm * 60 + ns;
    hits = '0;
    if (wrap && ns == 0)
      for (int i = 0; i < 4; i++) hits[i] = m_arm[i] && (m_ah[i] == nh) && (m_am[i] == nm);
    if (alm_stop) begin m_ring = 0; m_src = '0; m_left = 0; end
    else if (hits != 0) begin m_ring = 1; m_src |= hits; m_left = 3; end
    else if (m_ring && wrap) begin
      m_left--;
      if (m_left == 0) begin m_ring = 0; m_src = '0; end
    end
    if (alm_wr && alm_sel < 4) begin
      m_arm[alm_sel] = alm_arm; m_ah[alm_sel] = int'(alm_hour); m_am[alm_sel] = int'(alm_min);
    end
    m_ph = AdjH; m_pm = AdjM; m_tick = wrap;
  endtask

  task automatic check_all();
    int h, hd;
    h  = m_t / 3600;
    hd = Ctrl24To12 ? ((h == 0) ? 12 : ((h > 12) ? h - 12 : h)) : h;
    chk("hour_bcd", 16'(hour_bcd), bcd(hd));
    chk("min_bcd", 16'(min_bcd), bcd((m_t / 60) % 60));
    chk("sec_bcd", 16'(sec_bcd), bcd(m_t % 60));
    chk("pm", 16'(pm), 16'(h >= 12));
    chk("tick", 16'(tick), 16'(m_tick));
    chk("alarm_ring", 16'(alarm_ring), 16'(m_ring));
    chk("alarm_src", 16'(alarm_src), 16'(m_src));
`ifndef HOURLY_CHIME_EN
    chk("chime_off", 16'(chime), 16'd0);
`endif
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      model_next();
      @(posedge CP50);
      #1;
      check_all();
    end
  endtask

  task automatic adj_to(input int h, input int m);
    EN = 0;
    for (int k = 0; k < 30 && (m_t / 3600) != h; k++) begin AdjH = 1; step(1); AdjH = 0; step(1); end
    for (int k = 0; k < 70 && ((m_t / 60) % 60) != m; k++) begin AdjM = 1; step(1); AdjM = 0; step(1); end
  endtask

  task automatic run_to(input int h, input int m, input int s);
    int k;
    EN = 1; k = 0;
    while (m_t != h * 3600 + m * 60 + s && k < 2000) begin step(1); k++; end
    n_assert++;
    assert (k < 2000) else begin
      n_fail++;
      $error("FAIL run_to: cycles %0d expected below 2000 for %0d:%0d:%0d", k, h, m, s);
    end
  endtask

  task automatic write_alarm(input int sel, input int h, input int m, input bit arm);
    alm_wr = 1; alm_sel = 4'(sel); alm_hour = 5'(h); alm_min = 6'(m); alm_arm = arm;
    step(1);
    alm_wr = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_assert = 0; n_fail = 0;
    nCR = 0; EN = 0; Ctrl24To12 = 1; AdjH = 0; AdjM = 0; alm_wr = 0; alm_sel = '0;
    alm_hour = '0; alm_min = '0; alm_arm = 0; alm_stop = 0;
    model_reset();

    // Reset values, 12h display of hour 0
    step(2);
    chk("rst_hour12", 16'(hour_bcd), 16'h12);
    chk("rst_ring", 16'(alarm_ring), 16'd0);
    chk("rst_chime", 16'(chime), 16'd0);

    // One minute of free running
    nCR = 1; Ctrl24To12 = 0; EN = 1; ticks = 0;
    for (int k = 0; k < 240; k++) begin step(1); if (tick === 1'b1) ticks++; end
    chk("t1_ticks", 16'(ticks), 16'd60);
    chk("t1_min", 16'(min_bcd), 16'h01);
    chk("t1_sec", 16'(sec_bcd), 16'h00);

    // Day rollover and 12h display
    adj_to(23, 59);
    run_to(23, 59, 50);
    step(40);
    chk("t2_hour", 16'(hour_bcd), 16'h00);
    chk("t2_min", 16'(min_bcd), 16'h00);
    chk("t2_sec", 16'(sec_bcd), 16'h00);
    EN = 0; Ctrl24To12 = 1; step(1);
    chk("t2_h12", 16'(hour_bcd), 16'h12);
    chk("t2_pm0", 16'(pm), 16'd0);
    adj_to(13, 0);
    chk("t2_h13", 16'(hour_bcd), 16'h01);
    chk("t2_pm1", 16'(pm), 16'd1);

    // Single alarm ring, timeout, and adjust onto the alarm time
    Ctrl24To12 = 0;
    adj_to(0, 1);
    run_to(0, 1, 58);
    EN = 0;
    write_alarm(2, 0, 2, 1);
    run_to(0, 2, 0);
    chk("t3_ring", 16'(alarm_ring), 16'd1);
    chk("t3_src", 16'(alarm_src), 16'h4);
    step(8);
    chk("t3_ring_2t", 16'(alarm_ring), 16'd1);
    step(4);
    chk("t3_ring_off", 16'(alarm_ring), 16'd0);
    chk("t3_src_off", 16'(alarm_src), 16'h0);
    EN = 0;
    for (int k = 0; k < 60; k++) begin AdjM = 1; step(1); AdjM = 0; step(1); end
    chk("t3_adj_min", 16'(min_bcd), 16'h02);
    chk("t3_adj_noring", 16'(alarm_ring), 16'd0);

    // Two channels at once, stop, and stop coincident with a hit
    write_alarm(0, 0, 5, 1);
    write_alarm(3, 0, 5, 1);
    run_to(0, 5, 0);
    chk("t4_ring", 16'(alarm_ring), 16'd1);
    chk("t4_src", 16'(alarm_src), 16'h9);
    alm_stop = 1; step(1); alm_stop = 0;
    chk("t4_stop", 16'(alarm_ring), 16'd0);
    write_alarm(1, 0, 6, 1);
    run_to(0, 5, 59);
    step(3);
    alm_stop = 1; step(1); alm_stop = 0;
    chk("t4_stop_hit", 16'(alarm_ring), 16'd0);
    chk("t4_min", 16'(min_bcd), 16'h06);
    chk("t4_sec", 16'(sec_bcd), 16'h00);

    // Freeze with EN=0, adjust still works, out-of-range write ignored
    step(2);
    EN = 0; ticks = 0;
    for (int k = 0; k < 20; k++) begin step(1); if (tick === 1'b1) ticks++; end
    chk("t5_noticks", 16'(ticks), 16'd0);
    chk("t5_sec", 16'(sec_bcd), 16'h00);
    AdjM = 1; step(1); AdjM = 0; step(1);
    chk("t5_adjm", 16'(min_bcd), 16'h07);
    write_alarm(5, 0, 8, 1);
    run_to(0, 8, 1);
    chk("t5_sel5", 16'(alarm_ring), 16'd0);

    // Hour boundary into 15:00
    adj_to(14, 59);
    run_to(14, 59, 59);
    rises = 0; high = 0; prev_chime = 0;
    for (int k = 0; k < 44; k++) begin
      step(1);
      if (chime === 1'b1) high++;
      if (chime === 1'b1 && !prev_chime) rises++;
      prev_chime = (chime === 1'b1);
    end
`ifdef HOURLY_CHIME_EN
    chk("t6_rises", 16'(rises), 16'd3);
    chk("t6_high", 16'(high), 16'd12);
`else
    chk("t6_rises", 16'(rises), 16'd0);
    chk("t6_high", 16'(high), 16'd0);
`endif

    // Reset in the middle of a ring
    write_alarm(0, 15, 1, 1);
    run_to(15, 1, 0);
    chk("t7_ring", 16'(alarm_ring), 16'd1);
    Ctrl24To12 = 1; nCR = 0;
    step(1);
    chk("t7_hour", 16'(hour_bcd), 16'h12);
    chk("t7_min", 16'(min_bcd), 16'h00);
    chk("t7_sec", 16'(sec_bcd), 16'h00);
    chk("t7_pm", 16'(pm), 16'd0);
    chk("t7_tick", 16'(tick), 16'd0);
    chk("t7_ring_off", 16'(alarm_ring), 16'd0);
    chk("t7_src", 16'(alarm_src), 16'h0);
    chk("t7_chime", 16'(chime), 16'd0);
    nCR = 1; Ctrl24To12 = 0;

    // Random traffic, alarms biased toward the upcoming minute
    for (int k = 0; k < 4000; k++) begin
      nCR      = ($urandom_range(0, 599) != 0);
      EN       = ($urandom_range(0, 9) != 0);
      AdjH     = ($urandom_range(0, 49) == 0);
      AdjM     = ($urandom_range(0, 24) == 0);
      alm_stop = ($urandom_range(0, 39) == 0);
      alm_wr   = ($urandom_range(0, 19) == 0);
      alm_sel  = 4'($urandom_range(0, 7));
      alm_hour = ($urandom_range(0, 3) != 0) ? 5'(m_t / 3600) : 5'($urandom_range(0, 31));
      alm_min  = ($urandom_range(0, 3) != 0) ? 6'(((m_t / 60) + 1) % 60) : 6'($urandom_range(0, 63));
      alm_arm  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) Ctrl24To12 = ~Ctrl24To12;
      step(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
